// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity encodings and
// the data-bit-count decode used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // 2'b00..2'b11 selects 5..8 data bits.
  function automatic logic [3:0] data_bits(input logic [1:0] sel);
    return 4'd5 + {2'b00, sel};
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick every DIV = round(FREQUENCY_CLK/BAUD_RATE)
// clocks; clear restarts the period so the next tick lands DIV cycles later.
module uart_baud_tick #(
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned FREQUENCY_CLK = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned DIV   = (FREQUENCY_CLK + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !clear && (cnt_q == CNT_MAX);
    cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_BREAK_EN to add the tx_break input (holds the line low while idle).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned FREQUENCY_CLK = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  input  logic       cts_n,
`ifdef UART_TX_BREAK_EN
  input  logic       tx_break,
`endif
  output logic       tx
);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] last_bit_q;
  logic       stop_cnt_q, stop_cnt_d;
  logic       stop2_q, par_en_q, par_bit_q;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       rdy_en_q;
  logic       tick, accept, brk;
  logic [3:0] nbits;
  logic [7:0] mask;
  logic       par_calc;

`ifdef UART_TX_BREAK_EN
  assign brk = tx_break;
`else
  assign brk = 1'b0;
`endif

  uart_baud_tick #(
    .BAUD_RATE    (BAUD_RATE),
    .FREQUENCY_CLK(FREQUENCY_CLK)
  ) u_baud_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .tick   (tick)
  );

  // rdy_en_q keeps tx_ready low through reset and until the first clock after it.
  assign tx_ready = rdy_en_q && (state_q == IDLE) && !cts_n && !brk;
  assign accept   = tx_start && tx_ready;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;
  assign tx       = tx_q;

  // Parity is resolved at acceptance over only the bits that will be sent.
  assign nbits    = data_bits(data_bit_num);
  assign mask     = 8'hFF >> (4'd8 - nbits);
  assign par_calc = (^(tx_data & mask)) ^ (parity_type == PARITY_ODD);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = START;
          shift_d    = tx_data;
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == last_bit_q) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so each bit lines up with its state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = !brk;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      last_bit_q <= '0;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      rdy_en_q   <= 1'b1;
      if (accept) begin
        last_bit_q <= 3'(nbits - 4'd1);
        stop2_q    <= stop_bit_num;
        par_en_q   <= parity_en;
        par_bit_q  <= par_calc;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=16: expected line bits are queued when a
// frame is requested and popped as the serial line is sampled.
module tb_uart_tx;

  localparam int DIV = 16;

  logic       clk;
  logic       reset_n;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       cts_n;
  logic       tx;
`ifdef UART_TX_BREAK_EN
  logic       tx_break;
`endif

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  uart_tx #(
    .BAUD_RATE    (1),
    .FREQUENCY_CLK(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_bit_num(data_bit_num),
    .stop_bit_num(stop_bit_num),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .cts_n       (cts_n),
`ifdef UART_TX_BREAK_EN
    .tx_break    (tx_break),
`endif
    .tx          (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference frame: start, N data bits LSB first, parity, stop bit(s).
  task automatic push_frame(input logic [7:0] d, input logic [1:0] nsel, input logic pen,
                            input logic ptype, input logic s2);
    int   n;
    logic p;
    n = 5 + int'(nsel);
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pen) exp_q.push_back(p ^ ptype);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  // Drive a request at a negedge; returns at the negedge after the accepting edge.
  task automatic start_frame(input logic [7:0] d, input logic [1:0] nsel, input logic pen,
                             input logic ptype, input logic s2);
    tx_data      = d;
    data_bit_num = nsel;
    parity_en    = pen;
    parity_type  = ptype;
    stop_bit_num = s2;
    tx_start     = 1'b1;
    push_frame(d, nsel, pen, ptype, s2);
    chk("ready before start", tx_ready, 1'b1);
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Entered at the negedge of the first frame cycle; leaves at the tx_done cycle.
  task automatic check_frame(input string tag, input logic idle_tx);
    int   nb;
    logic done_early;
    logic busy_low;
    nb         = exp_q.size();
    done_early = 1'b0;
    busy_low   = 1'b0;
    for (int i = 0; i < nb; i++) begin
      logic b;
      logic seen;
      logic bad;
      b    = exp_q.pop_front();
      seen = b;
      bad  = 1'b0;
      for (int c = 0; c < DIV; c++) begin
        if (tx !== b && !bad) begin
          bad  = 1'b1;
          seen = tx;
        end
        if (tx_done !== 1'b0) done_early = 1'b1;
        if (tx_busy !== 1'b1) busy_low = 1'b1;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d", tag, i), seen, b);
    end
    chk({tag, " busy gap"}, busy_low, 1'b0);
    chk({tag, " early done"}, done_early, 1'b0);
    chk({tag, " done pulse"}, tx_done, 1'b1);
    chk({tag, " busy at end"}, tx_busy, 1'b0);
    chk({tag, " idle line"}, tx, idle_tx);
  endtask

  initial begin
    logic done_seen;
    logic line_low;
    reset_n      = 1'b0;
    cts_n        = 1'b0;
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    data_bit_num = 2'b11;
    stop_bit_num = 1'b0;
    parity_en    = 1'b0;
    parity_type  = 1'b0;
`ifdef UART_TX_BREAK_EN
    tx_break     = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset tx", tx, 1'b1);
    chk("reset ready", tx_ready, 1'b0);
    chk("reset busy", tx_busy, 1'b0);
    chk("reset done", tx_done, 1'b0);
    reset_n = 1'b1;
    chk("ready before first clk", tx_ready, 1'b0);
    @(negedge clk);
    chk("ready after first clk", tx_ready, 1'b1);

    // 8N1, 0xA5
    start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
    check_frame("8n1", 1'b1);
    @(negedge clk);
    chk("8n1 done width", tx_done, 1'b0);

    // 5 bits, even parity, 2 stop, upper bits of 0xE7 ignored
    start_frame(8'hE7, 2'b00, 1'b1, 1'b0, 1'b1);
    check_frame("5e2", 1'b1);
    @(negedge clk);

    // 7 bits, odd parity; config inputs scrambled mid-frame
    start_frame(8'h07, 2'b10, 1'b1, 1'b1, 1'b0);
    parity_type  = 1'b0;
    data_bit_num = 2'b11;
    stop_bit_num = 1'b1;
    tx_data      = 8'hFF;
    check_frame("7o1", 1'b1);
    @(negedge clk);

    // cts_n gating with tx_start held
    tx_data      = 8'h3C;
    data_bit_num = 2'b11;
    parity_en    = 1'b0;
    stop_bit_num = 1'b0;
    cts_n        = 1'b1;
    tx_start     = 1'b1;
    repeat (5) @(negedge clk);
    chk("cts blocked tx", tx, 1'b1);
    chk("cts blocked ready", tx_ready, 1'b0);
    chk("cts blocked busy", tx_busy, 1'b0);
    push_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0);
    cts_n = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    cts_n    = 1'b1;
    check_frame("cts", 1'b1);
    chk("cts ready after frame", tx_ready, 1'b0);
    cts_n = 1'b0;
    @(negedge clk);

    // Back-to-back frames with tx_start held
    tx_data  = 8'h55;
    tx_start = 1'b1;
    push_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tx_data = 8'h0F;
    check_frame("b2b first", 1'b1);
    chk("b2b ready at done", tx_ready, 1'b1);
    push_frame(8'h0F, 2'b11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tx_start = 1'b0;
    check_frame("b2b second", 1'b1);
    @(negedge clk);

    // Asynchronous reset in the middle of the data bits
    start_frame(8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
    repeat (DIV + 20) @(negedge clk);
    chk("abort line low", tx, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("abort async tx", tx, 1'b1);
    chk("abort busy", tx_busy, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset_n   = 1'b1;
    done_seen = 1'b0;
    line_low  = 1'b0;
    repeat (12 * DIV) begin
      @(negedge clk);
      if (tx_done !== 1'b0) done_seen = 1'b1;
      if (tx !== 1'b1) line_low = 1'b1;
    end
    chk("abort no done", done_seen, 1'b0);
    chk("abort line idle", line_low, 1'b0);

`ifdef UART_TX_BREAK_EN
    // Break in idle, then break requested mid-frame
    tx_break = 1'b1;
    @(negedge clk);
    chk("break idle tx", tx, 1'b0);
    chk("break idle ready", tx_ready, 1'b0);
    tx_break = 1'b0;
    @(negedge clk);
    chk("break release tx", tx, 1'b1);
    start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
    tx_break = 1'b1;
    check_frame("break mid", 1'b0);
    @(negedge clk);
    chk("break after frame", tx, 1'b0);
    tx_break = 1'b0;
    @(negedge clk);
    chk("break end tx", tx, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
